// File: rtl/qpsk_pkg.sv
// Shared definitions for the QPSK receive path: default phase scale, FSM
// states, the four QPSK carrier phase words and the symbol codes.
package qpsk_pkg;

  localparam int unsigned NBITS_DEF   = 24;
  localparam int unsigned PHASE_W_DEF = NBITS_DEF + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    DUMP  = 2'd2
  } state_t;

  // Carrier phase words for 45/135/225/315 degrees (full circle = 2**PHASE_W_DEF)
  localparam logic [PHASE_W_DEF-1:0] QPSK_PHASE_0 = PHASE_W_DEF'(64'd1 << NBITS_DEF);
  localparam logic [PHASE_W_DEF-1:0] QPSK_PHASE_1 = PHASE_W_DEF'(64'd3 << NBITS_DEF);
  localparam logic [PHASE_W_DEF-1:0] QPSK_PHASE_2 = PHASE_W_DEF'(64'd5 << NBITS_DEF);
  localparam logic [PHASE_W_DEF-1:0] QPSK_PHASE_3 = PHASE_W_DEF'(64'd7 << NBITS_DEF);

  localparam logic [1:0] SYM_0 = 2'd0;
  localparam logic [1:0] SYM_1 = 2'd1;
  localparam logic [1:0] SYM_2 = 2'd2;
  localparam logic [1:0] SYM_3 = 2'd3;

  // Quadrant slicer from the sign bits of the I and Q integrals
  function automatic logic [1:0] qpsk_slice(input logic i_neg, input logic q_neg);
    logic [1:0] s;
    case ({i_neg, q_neg})
      2'b00:   s = SYM_0;
      2'b10:   s = SYM_1;
      2'b11:   s = SYM_2;
      default: s = SYM_3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/qpsk_demodulator_integrator.sv
// I/Q sign-mixer and integrate-and-dump accumulators with sample counter.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   clr               zero accumulators and count
//   add               accumulate the mixed sample, count++
//   restart           load the mixed sample as sample 0 (count = 1)
//   adc_data          signed ADC sample
//   ref_i, ref_q      square-wave references (1 = +sample, 0 = -sample)
//   acc_i, acc_q      running integrals
//   count             samples accumulated in the current symbol
module qpsk_iq_integrator
  import qpsk_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned LW    = 16,
  parameter int unsigned ACC_W = DW + LW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    add,
  input  logic                    restart,
  input  logic signed [DW-1:0]    adc_data,
  input  logic                    ref_i,
  input  logic                    ref_q,
  output logic signed [ACC_W-1:0] acc_i,
  output logic signed [ACC_W-1:0] acc_q,
  output logic [LW-1:0]           count
);

  logic signed [ACC_W-1:0] samp_ext;
  logic signed [ACC_W-1:0] mix_i;
  logic signed [ACC_W-1:0] mix_q;

  // Sign-extend once, then flip sign where the reference is low
  assign samp_ext = ACC_W'(adc_data);
  assign mix_i    = ref_i ? samp_ext : -samp_ext;
  assign mix_q    = ref_q ? samp_ext : -samp_ext;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_i <= '0;
      acc_q <= '0;
      count <= '0;
    end else if (restart) begin
      acc_i <= mix_i;
      acc_q <= mix_q;
      count <= LW'(1);
    end else if (add) begin
      acc_i <= acc_i + mix_i;
      acc_q <= acc_q + mix_q;
      count <= count + LW'(1);
    end
  end

endmodule

// File: rtl/qpsk_demodulator.sv
// QPSK demodulator: NCO square-wave references, integrate-and-dump per
// symbol, quadrant slicer and a 1-deep valid/ready symbol buffer.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enable                   0 = idle, partial symbol discarded
//   carrier_freq             NCO increment per clk
//   phase_offset             carrier phase correction
//   sym_len                  samples per symbol (<2 treated as 2)
//   sym_start                restart symbol timing
//   adc_data, adc_valid      signed sample and qualifier
//   sym_data, sym_valid      sliced symbol, held until sym_ready
//   sym_ready                consumer accept
//   last_i, last_q           integrals of the last buffered symbol
//   overflow                 sticky: a symbol was dropped on a full buffer
module qpsk_demodulator
  import qpsk_pkg::*;
#(
  parameter int unsigned NBITS = NBITS_DEF,
  parameter int unsigned DW    = 16,
  parameter int unsigned LW    = 16,
  parameter int unsigned ACC_W = DW + LW + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NBITS-7:0]        carrier_freq,
  input  logic [NBITS+2:0]        phase_offset,
  input  logic [LW-1:0]           sym_len,
  input  logic                    sym_start,
  input  logic signed [DW-1:0]    adc_data,
  input  logic                    adc_valid,
  output logic [1:0]              sym_data,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic signed [ACC_W-1:0] last_i,
  output logic signed [ACC_W-1:0] last_q,
  output logic                    overflow
);

  localparam int unsigned PW = NBITS + 3;

  state_t                  state_q;
  state_t                  state_d;
  logic [PW-1:0]           phase_q;
  logic [1:0]              quad_c;
  logic                    sinp_c;
  logic                    cosp_c;
  logic [LW-1:0]           last_idx_c;
  logic                    clr_c;
  logic                    add_c;
  logic                    restart_c;
  logic                    dump_c;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic [LW-1:0]           count;

  // Free-running NCO
  always_ff @(posedge clk) begin
    if (rst) phase_q <= '0;
    else     phase_q <= phase_q + PW'(carrier_freq);
  end

  // Quadrant of the corrected phase drives the square-wave references
  assign quad_c = 2'((phase_q + phase_offset) >> (PW - 2));
  assign sinp_c = ~quad_c[1];
  assign cosp_c = ~(quad_c[1] ^ quad_c[0]);

  assign last_idx_c = (sym_len < LW'(2)) ? LW'(1) : sym_len - LW'(1);

  qpsk_iq_integrator #(
    .DW    (DW),
    .LW    (LW),
    .ACC_W (ACC_W)
  ) u_integ (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_c),
    .add      (add_c),
    .restart  (restart_c),
    .adc_data (adc_data),
    .ref_i    (cosp_c),
    .ref_q    (sinp_c),
    .acc_i    (acc_i),
    .acc_q    (acc_q),
    .count    (count)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and integrator control
  always_comb begin
    state_d   = state_q;
    clr_c     = 1'b0;
    add_c     = 1'b0;
    restart_c = 1'b0;
    dump_c    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      clr_c   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          clr_c   = 1'b1;
          state_d = INTEG;
        end
        INTEG: begin
          if (sym_start) begin
            clr_c = 1'b1;
          end else if (adc_valid) begin
            add_c = 1'b1;
            if (count == last_idx_c) state_d = DUMP;
          end
        end
        DUMP: begin
          state_d = INTEG;
          // sym_start cancels the dump; otherwise a sample here opens the next symbol
          if (sym_start) begin
            clr_c = 1'b1;
          end else begin
            dump_c = 1'b1;
            if (adc_valid) restart_c = 1'b1;
            else           clr_c     = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          clr_c   = 1'b1;
        end
      endcase
    end
  end

  // Output buffer: load on dump when free or draining, else drop and flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_data  <= '0;
      sym_valid <= 1'b0;
      last_i    <= '0;
      last_q    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (sym_valid && sym_ready) sym_valid <= 1'b0;
      if (dump_c) begin
        if (!sym_valid || sym_ready) begin
          sym_data  <= qpsk_slice(acc_i[ACC_W-1], acc_q[ACC_W-1]);
          last_i    <= acc_i;
          last_q    <= acc_q;
          sym_valid <= 1'b1;
        end else begin
          overflow  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpsk_demodulator.sv
// Directed bench for qpsk_demodulator with a capture queue of delivered symbols.
module tb_qpsk_demodulator;

  localparam int unsigned NB = 24;
  localparam int unsigned PW = NB + 3;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 16;
  localparam int unsigned AW = DW + LW + 1;

  localparam logic [PW-1:0] PH45  = 27'd16777216;
  localparam logic [PW-1:0] PH135 = 27'd50331648;
  localparam logic [PW-1:0] PH225 = 27'd83886080;
  localparam logic [PW-1:0] PH270 = 27'd100663296;
  localparam logic [PW-1:0] PH315 = 27'd117440512;

  logic                 clk;
  logic                 rst;
  logic                 enable;
  logic [NB-7:0]        carrier_freq;
  logic [PW-1:0]        phase_offset;
  logic [LW-1:0]        sym_len;
  logic                 sym_start;
  logic signed [DW-1:0] adc_data;
  logic                 adc_valid;
  logic [1:0]           sym_data;
  logic                 sym_valid;
  logic                 sym_ready;
  logic signed [AW-1:0] last_i;
  logic signed [AW-1:0] last_q;
  logic                 overflow;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [1:0]           q_sym[$];
  logic signed [AW-1:0] q_i[$];
  logic signed [AW-1:0] q_q[$];

  logic [PW-1:0] tx_ph;
  logic [PW-1:0] tx_qph [4];

  qpsk_demodulator dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .carrier_freq (carrier_freq),
    .phase_offset (phase_offset),
    .sym_len      (sym_len),
    .sym_start    (sym_start),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .sym_data     (sym_data),
    .sym_valid    (sym_valid),
    .sym_ready    (sym_ready),
    .last_i       (last_i),
    .last_q       (last_q),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Modulator-side carrier phase, restarted by the same reset
  always @(posedge clk) begin
    if (rst) tx_ph <= '0;
    else     tx_ph <= tx_ph + PW'(carrier_freq);
  end

  // Record every accepted symbol
  always @(negedge clk) begin
    if (!rst && sym_valid && sym_ready) begin
      q_sym.push_back(sym_data);
      q_i.push_back(last_i);
      q_q.push_back(last_q);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int n, input logic signed [DW-1:0] d);
    for (int k = 0; k < n; k++) begin
      adc_data  = d;
      adc_valid = 1'b1;
      tick();
    end
    adc_valid = 1'b0;
  endtask

  task automatic expect_sym(input string tag, input int es, input int ei,
                            input int eq, input bit check_iq);
    logic [1:0]           s;
    logic signed [AW-1:0] vi;
    logic signed [AW-1:0] vq;
    int n;
    n = 0;
    while (q_sym.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    if (q_sym.size() == 0) begin
      chk({tag, "_timeout"}, q_sym.size(), 1);
    end else begin
      s  = q_sym.pop_front();
      vi = q_i.pop_front();
      vq = q_q.pop_front();
      chk({tag, "_sym"}, s, es);
      if (check_iq) begin
        chk({tag, "_i"}, vi, ei);
        chk({tag, "_q"}, vq, eq);
      end
    end
  endtask

  initial begin
    logic [PW-1:0] tp;
    tx_qph[0] = PH45;
    tx_qph[1] = PH135;
    tx_qph[2] = PH225;
    tx_qph[3] = PH315;

    rst          = 1'b1;
    enable       = 1'b0;
    carrier_freq = '0;
    phase_offset = '0;
    sym_len      = 16'd8;
    sym_start    = 1'b0;
    adc_data     = '0;
    adc_valid    = 1'b0;
    sym_ready    = 1'b1;
    tick(2);

    chk("rst_valid", sym_valid, 0);
    chk("rst_data", sym_data, 0);
    chk("rst_last_i", last_i, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;

    // Constant input, each quadrant offset
    enable       = 1'b1;
    phase_offset = PH45;
    tick();
    drive(8, 16'sd1000);
    expect_sym("c45", 0, 8000, 8000, 1'b1);
    phase_offset = PH225;
    drive(8, 16'sd1000);
    expect_sym("c225", 2, -8000, -8000, 1'b1);
    phase_offset = PH270;
    drive(8, 16'sd1000);
    expect_sym("c270", 3, 8000, -8000, 1'b1);
    phase_offset = PH135;
    drive(8, 16'sd1000);
    expect_sym("c135", 1, -8000, 8000, 1'b1);

    // sym_len below 2 acts as 2; back-to-back symbols through DUMP
    sym_len      = 16'd1;
    phase_offset = PH45;
    drive(4, 16'sd1000);
    expect_sym("len1_a", 0, 2000, 2000, 1'b1);
    expect_sym("len1_b", 0, 2000, 2000, 1'b1);
    sym_len = 16'd8;

    // sym_start discards a partial symbol
    phase_offset = PH225;
    drive(5, 16'sd1000);
    sym_start = 1'b1;
    adc_data  = 16'sd1000;
    adc_valid = 1'b1;
    tick();
    sym_start    = 1'b0;
    phase_offset = PH45;
    drive(8, 16'sd1000);
    expect_sym("start", 0, 8000, 8000, 1'b1);
    tick(20);
    chk("start_none", q_sym.size(), 0);

    // enable=0 discards a partial symbol
    drive(5, 16'sd1000);
    enable = 1'b0;
    tick();
    chk("en_acc_i", dut.u_integ.acc_i, 0);
    chk("en_count", dut.u_integ.count, 0);
    enable = 1'b1;
    tick();
    drive(8, 16'sd1000);
    expect_sym("en", 0, 8000, 8000, 1'b1);
    tick(20);
    chk("en_none", q_sym.size(), 0);

    // Full buffer: first symbol held, later ones dropped
    sym_ready = 1'b0;
    drive(8, 16'sd1000);
    phase_offset = PH225;
    drive(16, 16'sd1000);
    tick(3);
    chk("ovf_valid", sym_valid, 1);
    chk("ovf_data", sym_data, 0);
    chk("ovf_last_i", last_i, 8000);
    chk("ovf_last_q", last_q, 8000);
    chk("ovf_flag", overflow, 1);
    sym_ready = 1'b1;
    expect_sym("ovf_out", 0, 8000, 8000, 1'b1);
    tick(2);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_drained", sym_valid, 0);

    // rst mid-symbol with a held symbol and overflow set
    sym_ready    = 1'b0;
    phase_offset = PH45;
    drive(8, 16'sd1000);
    drive(5, 16'sd1000);
    chk("pre_rst_valid", sym_valid, 1);
    rst = 1'b1;
    tick();
    chk("mrst_valid", sym_valid, 0);
    chk("mrst_ovf", overflow, 0);
    chk("mrst_last_i", last_i, 0);
    chk("mrst_acc_q", dut.u_integ.acc_q, 0);
    rst       = 1'b0;
    sym_ready = 1'b1;
    tick();
    drive(3, 16'sd1000);
    tick(20);
    chk("mrst_none", q_sym.size(), 0);

    // Loopback against a square-wave modulator model
    carrier_freq = 18'd178176;
    sym_len      = 16'd1507;
    phase_offset = '0;
    rst          = 1'b1;
    tick(2);
    rst = 1'b0;
    tick();
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 1507; n++) begin
        tp        = tx_ph - tx_qph[s];
        adc_data  = (~(tp[PW-1] ^ tp[PW-2])) ? 16'sd1000 : -16'sd1000;
        adc_valid = 1'b1;
        tick();
      end
    end
    adc_valid = 1'b0;
    expect_sym("loop0", 0, 0, 0, 1'b0);
    expect_sym("loop1", 1, 0, 0, 1'b0);
    expect_sym("loop2", 2, 0, 0, 1'b0);
    expect_sym("loop3", 3, 0, 0, 1'b0);
    chk("loop_ovf", overflow, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
